// File: rtl/svcs_trnx_arbiter.sv
// svcs_trnx_arbiter
//
// Round-robin arbiter that grants one of N_REQ requesters at a time and
// serialises its transaction onto a single output stream. Each transaction is
// a three-word header (trnx_type with out_sof, trnx_id, payload count),
// followed by the winner's payload words passed through combinationally.
// Requests whose payload count exceeds MAX_PAYLOADS are rejected with a
// one-cycle grant and an err_size pulse, and produce no output beats.
//
// Ports
//   clk, rst          : clock (rising edge), asynchronous active-high reset
//   req               : per-requester request, held until granted
//   req_trnx_type     : per-requester header type word      (N_REQ*DATA_W)
//   req_trnx_id       : per-requester header id word        (N_REQ*DATA_W)
//   req_n_payloads    : per-requester payload count         (N_REQ*13)
//   gnt               : one-hot grant, held for the whole transaction
//   pl_valid, pl_data : per-requester payload stream in
//   pl_ready          : per-requester payload accept (winner only, PAYLOAD only)
//   out_valid/out_data/out_sof/out_last, out_ready : output stream
//   busy              : high whenever the FSM is not idle
//   err_size          : one-cycle pulse on a rejected oversize request

module svcs_trnx_arbiter #(
    parameter int unsigned N_REQ        = 4,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned MAX_PAYLOADS = 4096
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] req_trnx_type,
    input  logic [N_REQ*DATA_W-1:0] req_trnx_id,
    input  logic [N_REQ*13-1:0]     req_n_payloads,
    output logic [N_REQ-1:0]        gnt,
    input  logic [N_REQ-1:0]        pl_valid,
    input  logic [N_REQ*DATA_W-1:0] pl_data,
    output logic [N_REQ-1:0]        pl_ready,
    output logic                    out_valid,
    output logic [DATA_W-1:0]       out_data,
    output logic                    out_sof,
    output logic                    out_last,
    input  logic                    out_ready,
    output logic                    busy,
    output logic                    err_size
);

    localparam int unsigned IdxW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    // Bits of the payload count that fit into an output word.
    localparam int unsigned NpW   = (DATA_W < 13) ? DATA_W : 13;
    localparam logic [13:0] MaxPl = 14'(MAX_PAYLOADS);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_HDR_TYPE = 3'd1;
    localparam logic [2:0] S_HDR_ID   = 3'd2;
    localparam logic [2:0] S_HDR_NP   = 3'd3;
    localparam logic [2:0] S_PAYLOAD  = 3'd4;
    localparam logic [2:0] S_ERR      = 3'd5;

    logic [2:0]        state_q, state_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    // Updated at the grant edge, so outside IDLE this is also the current winner.
    logic [IdxW-1:0]   last_winner_q, last_winner_d;
    logic [DATA_W-1:0] type_q, type_d;
    logic [DATA_W-1:0] id_q, id_d;
    logic [12:0]       np_q, np_d;
    logic [12:0]       cnt_q, cnt_d;

    logic              rr_found;
    logic [IdxW-1:0]   rr_idx;
    logic [DATA_W-1:0] sel_type;
    logic [DATA_W-1:0] sel_id;
    logic [12:0]       sel_np;
    logic              beat;

    // Round-robin search starting just above the previous winner.
    always_comb begin
        int unsigned cand;
        rr_found = 1'b0;
        rr_idx   = '0;
        cand     = 0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand = (32'(last_winner_q) + k) % N_REQ;
            if (!rr_found && req[cand]) begin
                rr_found = 1'b1;
                rr_idx   = IdxW'(cand);
            end
        end
    end

    always_comb begin
        sel_type = req_trnx_type[32'(rr_idx) * DATA_W +: DATA_W];
        sel_id   = req_trnx_id[32'(rr_idx) * DATA_W +: DATA_W];
        sel_np   = req_n_payloads[32'(rr_idx) * 13 +: 13];
    end

    assign beat = out_valid && out_ready;

    // Next-state logic.
    always_comb begin
        state_d       = state_q;
        gnt_d         = gnt_q;
        last_winner_d = last_winner_q;
        type_d        = type_q;
        id_d          = id_q;
        np_d          = np_q;
        cnt_d         = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (rr_found) begin
                    last_winner_d  = rr_idx;
                    gnt_d          = '0;
                    gnt_d[rr_idx]  = 1'b1;
                    type_d         = sel_type;
                    id_d           = sel_id;
                    np_d           = sel_np;
                    cnt_d          = sel_np;
                    state_d        = ({1'b0, sel_np} > MaxPl) ? S_ERR : S_HDR_TYPE;
                end
            end
            S_HDR_TYPE: begin
                if (beat) state_d = S_HDR_ID;
            end
            S_HDR_ID: begin
                if (beat) state_d = S_HDR_NP;
            end
            S_HDR_NP: begin
                if (beat) begin
                    if (np_q == 13'd0) begin
                        state_d = S_IDLE;
                        gnt_d   = '0;
                    end else begin
                        state_d = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (beat) begin
                    cnt_d = cnt_q - 13'd1;
                    if (cnt_q == 13'd1) begin
                        state_d = S_IDLE;
                        gnt_d   = '0;
                    end
                end
            end
            S_ERR: begin
                state_d = S_IDLE;
                gnt_d   = '0;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            gnt_q         <= '0;
            last_winner_q <= IdxW'(N_REQ - 1);
            type_q        <= '0;
            id_q          <= '0;
            np_q          <= '0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            gnt_q         <= gnt_d;
            last_winner_q <= last_winner_d;
            type_q        <= type_d;
            id_q          <= id_d;
            np_q          <= np_d;
            cnt_q         <= cnt_d;
        end
    end

    // Output stream: header words come from the latched copies, payload words
    // pass straight through from the winner so a pl_valid gap stalls the output.
    always_comb begin
        out_valid = 1'b0;
        out_data  = '0;
        out_sof   = 1'b0;
        out_last  = 1'b0;
        pl_ready  = '0;

        case (state_q)
            S_HDR_TYPE: begin
                out_valid = 1'b1;
                out_data  = type_q;
                out_sof   = 1'b1;
            end
            S_HDR_ID: begin
                out_valid = 1'b1;
                out_data  = id_q;
            end
            S_HDR_NP: begin
                out_valid          = 1'b1;
                out_data[NpW-1:0]  = np_q[NpW-1:0];
                out_last           = (np_q == 13'd0);
            end
            S_PAYLOAD: begin
                out_valid               = pl_valid[last_winner_q];
                out_data                = pl_data[32'(last_winner_q) * DATA_W +: DATA_W];
                out_last                = (cnt_q == 13'd1);
                pl_ready[last_winner_q] = out_ready;
            end
            default: begin
            end
        endcase
    end

    assign gnt      = gnt_q;
    assign busy     = (state_q != S_IDLE);
    assign err_size = (state_q == S_ERR);

endmodule
